// File: rtl/toy_pkg.sv
// Shared constants for the TOY memory-mapped I/O block: STATUS field
// positions, the default window base and a constant-width helper.
package toy_pkg;

    localparam int ST_RX_NEMPTY = 0;
    localparam int ST_TX_NFULL  = 1;
    localparam int ST_RX_OVF    = 2;
    localparam int ST_TX_OVF    = 3;
    localparam int ST_RX_UNF    = 4;
    localparam int ST_RXCNT_LSB = 8;

    localparam logic [7:0] TOY_IO_BASE = 8'hF0;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/toy_fifo.sv
// Synchronous FIFO with extra-MSB pointers. A pop in the same cycle frees a
// slot for a push while full; an empty FIFO presents 0 on rdata.
module toy_fifo
    import toy_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count = wptr_q - rptr_q;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    assign rptr_d = rptr_q + {{AW{1'b0}}, do_pop};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/toy_mmio_ctrl.sv
// Multi-channel MMIO controller: per channel an RX FIFO (producer to CPU) and
// a TX FIFO (CPU to consumer), DATA/STATUS register pairs at the top of memory.
module toy_mmio_ctrl
    import toy_pkg::*;
#(
    parameter int                 DATA_W     = 16,
    parameter int                 ADDR_W     = 8,
    parameter int                 NUM_CH     = 2,
    parameter int                 FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = ADDR_W'(TOY_IO_BASE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     read,
    input  logic                     write,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     hit,
    input  logic [NUM_CH-1:0]        rx_valid,
    input  logic [NUM_CH*DATA_W-1:0] rx_data,
    output logic [NUM_CH-1:0]        rx_ready,
    output logic [NUM_CH-1:0]        tx_valid,
    output logic [NUM_CH*DATA_W-1:0] tx_data,
    input  logic [NUM_CH-1:0]        tx_ready
);

    localparam int                AW        = clog2(FIFO_DEPTH);
    localparam int                CW        = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] WIN_WORDS = ADDR_W'(2 * NUM_CH);

    logic [ADDR_W-1:0] off;
    logic [CW-1:0]     sel_ch;
    logic              sel_data;
    logic              sel_status;

    logic              read_q;
    logic              is_data_q;
    logic [CW-1:0]     ch_q;
    logic              pop_strobe;

    logic [DATA_W-1:0] rx_head  [NUM_CH];
    logic [DATA_W-1:0] status_w [NUM_CH];

    assign off        = addr - BASE_ADDR;
    assign hit        = (addr >= BASE_ADDR) && (off < WIN_WORDS);
    assign sel_ch     = off[ADDR_W-1:1];
    assign sel_data   = hit && !off[0];
    assign sel_status = hit && off[0];

    // The target is captured on every read cycle so the pop, which fires on
    // the falling edge of read, acts on what the CPU was actually reading.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_q    <= 1'b0;
            is_data_q <= 1'b0;
            ch_q      <= '0;
        end else begin
            read_q <= read;
            if (read) begin
                is_data_q <= sel_data;
                ch_q      <= sel_ch;
            end
        end
    end

    assign pop_strobe = !read && read_q && is_data_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
        logic              ch_match;
        logic              rx_push, rx_pop, tx_push, status_wr;
        logic              rx_full, rx_empty, tx_full, tx_empty;
        logic [AW:0]       rx_cnt;
        logic [AW:0]       tx_cnt_unused;
        logic [DATA_W-1:0] rx_rdata, tx_rdata;
        logic [2:0]        sticky_q, sticky_d, sticky_set, sticky_clr;
        logic [DATA_W-1:0] status_word;

        assign ch_match  = (sel_ch == CW'(c));
        assign rx_push   = rx_valid[c] && !rx_full;
        assign rx_pop    = pop_strobe && (ch_q == CW'(c));
        assign tx_push   = write && sel_data && ch_match;
        assign status_wr = write && sel_status && ch_match;

        toy_fifo #(
            .WIDTH (DATA_W),
            .DEPTH (FIFO_DEPTH)
        ) u_rx_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (rx_push),
            .pop   (rx_pop),
            .wdata (rx_data[c*DATA_W +: DATA_W]),
            .rdata (rx_rdata),
            .full  (rx_full),
            .empty (rx_empty),
            .count (rx_cnt)
        );

        toy_fifo #(
            .WIDTH (DATA_W),
            .DEPTH (FIFO_DEPTH)
        ) u_tx_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (tx_push),
            .pop   (tx_ready[c]),
            .wdata (din),
            .rdata (tx_rdata),
            .full  (tx_full),
            .empty (tx_empty),
            .count (tx_cnt_unused)
        );

        assign rx_ready[c]                  = !rx_full;
        assign tx_valid[c]                  = !tx_empty;
        assign tx_data[c*DATA_W +: DATA_W]  = tx_rdata;
        assign rx_head[c]                   = rx_rdata;

        // Sticky order {rx_unf, tx_ovf, rx_ovf} mirrors STATUS bits 4..2.
        // A full TX FIFO drops a write only if the consumer is not popping.
        assign sticky_set[0] = rx_valid[c] && rx_full;
        assign sticky_set[1] = tx_push && tx_full && !tx_ready[c];
        assign sticky_set[2] = rx_pop && rx_empty;
        assign sticky_clr    = status_wr ? din[ST_RX_UNF:ST_RX_OVF] : 3'b000;
        assign sticky_d      = (sticky_q & ~sticky_clr) | sticky_set;

        always_ff @(posedge clk) begin
            if (reset) begin
                sticky_q <= '0;
            end else begin
                sticky_q <= sticky_d;
            end
        end

        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        always_comb begin
            status_word                            = '0;
            status_word[ST_RX_NEMPTY]              = !rx_empty;
            status_word[ST_TX_NFULL]               = !tx_full;
            status_word[ST_RX_UNF:ST_RX_OVF]       = sticky_q;
            status_word[ST_RXCNT_LSB +: AW+1]      = rx_cnt;
        end

        assign status_w[c] = status_word;
    end

    always_comb begin
        dout = '0;
        if (hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel_ch == CW'(i)) begin
                    dout = off[0] ? status_w[i] : rx_head[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_toy_mmio_ctrl.sv
// Self-checking bench for toy_mmio_ctrl: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_toy_mmio_ctrl;

    localparam int         DATA_W     = 16;
    localparam int         ADDR_W     = 8;
    localparam int         NUM_CH     = 2;
    localparam int         FIFO_DEPTH = 8;
    localparam logic [7:0] BASE       = 8'hF0;

    logic                     clk;
    logic                     reset;
    logic [ADDR_W-1:0]        addr;
    logic                     read;
    logic                     write;
    logic [DATA_W-1:0]        din;
    logic [DATA_W-1:0]        dout;
    logic                     hit;
    logic [NUM_CH-1:0]        rx_valid;
    logic [NUM_CH*DATA_W-1:0] rx_data;
    logic [NUM_CH-1:0]        rx_ready;
    logic [NUM_CH-1:0]        tx_valid;
    logic [NUM_CH*DATA_W-1:0] tx_data;
    logic [NUM_CH-1:0]        tx_ready;

    toy_mmio_ctrl #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .read     (read),
        .write    (write),
        .din      (din),
        .dout     (dout),
        .hit      (hit),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [DATA_W-1:0] word_q_t [$];

    word_q_t rxq [NUM_CH];
    word_q_t txq [NUM_CH];
    bit      rx_ovf_m [NUM_CH];
    bit      tx_ovf_m [NUM_CH];
    bit      rx_unf_m [NUM_CH];
    bit      read_prev;
    bit      lat_data;
    int      lat_ch;

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void decode(input logic [7:0] a, output bit h, output bit is_status,
                                   output int ch);
        logic [7:0] o;
        o         = a - BASE;
        h         = (a >= BASE) && (int'(o) < 2 * NUM_CH);
        is_status = o[0];
        ch        = int'(o) / 2;
    endfunction

    function automatic logic [DATA_W-1:0] model_status(input int c);
        int s;
        s = 0;
        if (rxq[c].size() > 0)          s += 1;
        if (txq[c].size() < FIFO_DEPTH) s += 2;
        if (rx_ovf_m[c])                s += 4;
        if (tx_ovf_m[c])                s += 8;
        if (rx_unf_m[c])                s += 16;
        s += rxq[c].size() * 256;
        return DATA_W'(s);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            rxq[c].delete();
            txq[c].delete();
            rx_ovf_m[c] = 0;
            tx_ovf_m[c] = 0;
            rx_unf_m[c] = 0;
        end
        read_prev = 0;
        lat_data  = 0;
        lat_ch    = 0;
    endtask

    // Applies one clock edge's worth of behaviour using the current inputs.
    task automatic model_update();
        bit h, st;
        int ch;
        if (reset) begin
            model_reset();
            return;
        end
        decode(addr, h, st, ch);
        for (int c = 0; c < NUM_CH; c++) begin
            bit pop_rx;
            bit rx_was_full;
            pop_rx      = !read && read_prev && lat_data && (lat_ch == c);
            rx_was_full = (rxq[c].size() == FIFO_DEPTH);
            if (write && h && st && ch == c) begin
                if (din[2]) rx_ovf_m[c] = 0;
                if (din[3]) tx_ovf_m[c] = 0;
                if (din[4]) rx_unf_m[c] = 0;
            end
            if (pop_rx) begin
                if (rxq[c].size() > 0) void'(rxq[c].pop_front());
                else rx_unf_m[c] = 1;
            end
            if (rx_valid[c]) begin
                if (!rx_was_full) rxq[c].push_back(rx_data[c*DATA_W +: DATA_W]);
                else rx_ovf_m[c] = 1;
            end
            if (tx_ready[c] && txq[c].size() > 0) void'(txq[c].pop_front());
            if (write && h && !st && ch == c) begin
                if (txq[c].size() < FIFO_DEPTH) txq[c].push_back(din);
                else tx_ovf_m[c] = 1;
            end
        end
        read_prev = read;
        if (read) begin
            lat_ch   = ch;
            lat_data = h && !st;
        end
    endtask

    task automatic compare_outputs();
        bit                       h, st;
        int                       ch;
        logic [DATA_W-1:0]        e_dout;
        logic [NUM_CH-1:0]        e_rdy, e_tv;
        logic [NUM_CH*DATA_W-1:0] e_td;
        decode(addr, h, st, ch);
        e_dout = '0;
        if (h) e_dout = st ? model_status(ch) : (rxq[ch].size() > 0 ? rxq[ch][0] : '0);
        for (int c = 0; c < NUM_CH; c++) begin
            e_rdy[c] = rxq[c].size() < FIFO_DEPTH;
            e_tv[c]  = txq[c].size() > 0;
            e_td[c*DATA_W +: DATA_W] = e_tv[c] ? txq[c][0] : '0;
        end
        check("hit", hit, h);
        check("dout", dout, e_dout);
        check("rx_ready", rx_ready, e_rdy);
        check("tx_valid", tx_valid, e_tv);
        check("tx_data", tx_data, e_td);
    endtask

    // Check outputs mid-cycle, advance the model, then cross the edge.
    task automatic step();
        @(negedge clk);
        compare_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        addr     = '0;
        read     = 1'b0;
        write    = 1'b0;
        din      = '0;
        rx_valid = '0;
        rx_data  = '0;
        tx_ready = '0;
        @(posedge clk);
        #1;
        model_reset();
        addr = BASE;
        step();
        check("rst_rx_ready", rx_ready, 2'b11);
        check("rst_tx_valid", tx_valid, 2'b00);
        check("rst_tx_data", tx_data, 32'h0);
        check("rst_dout", dout, 16'h0);
        reset = 1'b0;

        // 1: single RX word, multi-cycle read pops exactly once.
        rx_data[15:0] = 16'hCAFE;
        rx_valid      = 2'b01;
        step();
        rx_valid = '0;
        addr     = BASE;
        read     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_dout_hold", dout, 16'hCAFE);
        end
        read = 1'b0;
        step();
        addr = BASE + 8'd1;
        step();
        check("t1_nempty", dout[0], 1'b0);
        check("t1_count", dout[11:8], 4'd0);

        // 2: fill ch1 RX, overflow on the ninth word, drain in order.
        for (int i = 1; i <= 9; i++) begin
            rx_data[31:16] = 16'(i);
            rx_valid       = 2'b10;
            step();
        end
        check("t2_rx_ready", rx_ready[1], 1'b0);
        rx_valid = '0;
        addr     = BASE + 8'd3;
        step();
        check("t2_rx_ovf", dout[2], 1'b1);
        check("t2_count", dout[11:8], 4'd8);
        addr = BASE + 8'd2;
        for (int i = 1; i <= 8; i++) begin
            read = 1'b1;
            step();
            check("t2_order", dout, 16'(i));
            read = 1'b0;
            step();
        end

        // 3: underflow on empty ch0, then clear it with a W1C write.
        addr = BASE;
        read = 1'b1;
        step();
        check("t3_empty_dout", dout, 16'h0);
        read = 1'b0;
        step();
        addr = BASE + 8'd1;
        step();
        check("t3_unf_set", dout[4], 1'b1);
        din   = 16'h0010;
        write = 1'b1;
        step();
        write = 1'b0;
        check("t3_unf_clr", dout[4], 1'b0);
        check("t3_others", dout[3:0], 4'b0010);

        // 4: TX overflow with a stalled consumer, then drain one per cycle.
        tx_ready = '0;
        addr     = BASE;
        write    = 1'b1;
        for (int i = 0; i < 9; i++) begin
            din = 16'(16'h0100 + i);
            step();
        end
        write = 1'b0;
        check("t4_tx_valid", tx_valid[0], 1'b1);
        check("t4_head", tx_data[15:0], 16'h0100);
        addr = BASE + 8'd1;
        step();
        check("t4_tx_ovf", dout[3], 1'b1);
        tx_ready = 2'b01;
        for (int i = 0; i < 8; i++) begin
            check("t4_drain", tx_data[15:0], 16'(16'h0100 + i));
            step();
        end
        check("t4_tx_empty", tx_valid[0], 1'b0);
        tx_ready = '0;

        // 5: simultaneous push/pop on a full TX FIFO and on RX.
        din   = 16'h0008;
        write = 1'b1;
        step();
        addr = BASE;
        for (int i = 0; i < 8; i++) begin
            din = 16'(16'h0200 + i);
            step();
        end
        din      = 16'hBEEF;
        tx_ready = 2'b01;
        step();
        write    = 1'b0;
        tx_ready = '0;
        addr     = BASE + 8'd1;
        step();
        check("t5_tx_still_full", dout[1], 1'b0);
        check("t5_no_tx_ovf", dout[3], 1'b0);
        check("t5_tx_head", tx_data[15:0], 16'h0201);
        rx_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            rx_data[15:0] = 16'(16'h0300 + i);
            step();
        end
        rx_valid = '0;
        addr     = BASE;
        read     = 1'b1;
        step();
        read          = 1'b0;
        rx_valid      = 2'b01;
        rx_data[15:0] = 16'h0304;
        step();
        rx_valid = '0;
        addr     = BASE + 8'd1;
        step();
        check("t5_rx_count", dout[11:8], 4'd4);
        tx_ready = 2'b11;
        for (int i = 0; i < 9; i++) step();
        tx_ready = '0;

        // 6: reset in the middle of a DATA read.
        addr = BASE;
        read = 1'b1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        read  = 1'b0;
        step();
        check("t6_rx_ready", rx_ready, 2'b11);
        addr = BASE + 8'd1;
        step();
        check("t6_count", dout[11:8], 4'd0);
        addr = 8'h10;
        step();
        check("t6_hit", hit, 1'b0);
        check("t6_dout", dout, 16'h0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (!read) begin
                if ($urandom_range(0, 3) != 0) addr = BASE + 8'($urandom_range(0, 3));
                else addr = 8'($urandom_range(0, 255));
            end
            if (read) read = ($urandom_range(0, 2) != 0);
            else read = ($urandom_range(0, 3) == 0);
            write    = read ? 1'b0 : ($urandom_range(0, 3) == 0);
            din      = 16'($urandom);
            rx_valid = 2'($urandom_range(0, 3));
            rx_data  = 32'($urandom);
            tx_ready = 2'($urandom_range(0, 3));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
